fir_cfg_master: RTL and testbench

AXI-lite initiator that issues configuration writes, status reads and status polls to the FIR engine's AXI-lite responder port. A simple command/response interface lets a local sequencer or CPU shim write ap_start, data length and tap coefficients, then wait for ap_done without having to drive the AXI-lite handshakes itself. It sits between the control logic and the FIR `awaddr/wdata/araddr/rdata` port.

---
 rtl/fir_cfg_master_if.sv | 32 +++
 rtl/fir_cfg_master.sv | 220 ++++++++++++++++++++++
 tb/tb_fir_cfg_master.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_cfg_master_if.sv
// AXI-lite bus between fir_cfg_master (initiator) and the FIR engine responder port.
interface fir_cfg_master_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   awvalid;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   awready;
    logic                   wvalid;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   wready;
    logic                   arvalid;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   arready;
    logic                   rvalid;
    logic [pDATA_WIDTH-1:0] rdata;
    logic                   rready;

    modport master (
        output awvalid, awaddr, input awready,
        output wvalid, wdata, input wready,
        output arvalid, araddr, input arready,
        input rvalid, rdata, output rready
    );

    modport slave (
        input awvalid, awaddr, output awready,
        input wvalid, wdata, output wready,
        input arvalid, araddr, output arready,
        output rvalid, rdata, input rready
    );
endinterface

// File: rtl/fir_cfg_master.sv
// AXI-lite initiator turning write/read/poll commands into FIR responder transactions.
// The poll op (CHK state, attempt counter, timeout) exists only when FIR_CFG_POLL_EN is defined.
module fir_cfg_master #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pPOLL_LIMIT = 1023
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [pADDR_WIDTH-1:0] cmd_addr,
    input  logic [pDATA_WIDTH-1:0] cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [pDATA_WIDTH-1:0] rsp_rdata,
    output logic                   rsp_timeout,
    fir_cfg_master_if.master       axil
);

`ifdef FIR_CFG_POLL_EN
    localparam int CNT_W = $clog2(pPOLL_LIMIT + 1);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_WR = 3'd1, S_RD = 3'd2, S_CHK = 3'd3, S_RSP = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_WR = 3'd1, S_RD = 3'd2, S_RSP = 3'd4
    } state_t;
`endif

    state_t                 state_r, state_s;
    logic [pADDR_WIDTH-1:0] awaddr_r, awaddr_s, araddr_r, araddr_s;
    logic [pDATA_WIDTH-1:0] wdata_r, wdata_s, rdata_r, rdata_s;
    logic                   awvalid_r, awvalid_s, wvalid_r, wvalid_s;
    logic                   arvalid_r, arvalid_s, rready_r, rready_s;
    logic                   cmd_ready_r, cmd_ready_s, rsp_valid_r, rsp_valid_s;
`ifdef FIR_CFG_POLL_EN
    logic                   poll_r, poll_s, timeout_r, timeout_s;
    logic [pADDR_WIDTH-1:0] addr_r, addr_s;
    logic [pDATA_WIDTH-1:0] mask_r, mask_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
`endif

    // Next-state and next-output computation; every register holds by default.
    always_comb begin
        state_s   = state_r;
        awaddr_s  = awaddr_r;
        araddr_s  = araddr_r;
        wdata_s   = wdata_r;
        rdata_s   = rdata_r;
        awvalid_s = awvalid_r;
        wvalid_s  = wvalid_r;
        arvalid_s = arvalid_r;
        rready_s  = rready_r;
`ifdef FIR_CFG_POLL_EN
        poll_s    = poll_r;
        timeout_s = timeout_r;
        addr_s    = addr_r;
        mask_s    = mask_r;
        cnt_s     = cnt_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == 2'b00) begin
                        state_s   = S_WR;
                        awvalid_s = 1'b1;
                        wvalid_s  = 1'b1;
                        awaddr_s  = cmd_addr;
                        wdata_s   = cmd_wdata;
                        rdata_s   = '0;
                    end else begin
                        state_s   = S_RD;
                        arvalid_s = 1'b1;
                        rready_s  = 1'b1;
                        araddr_s  = cmd_addr;
                    end
`ifdef FIR_CFG_POLL_EN
                    poll_s    = (cmd_op == 2'b10);
                    timeout_s = 1'b0;
                    addr_s    = cmd_addr;
                    mask_s    = cmd_wdata;
                    cnt_s     = '0;
`endif
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WR: begin
                awvalid_s = awvalid_r & ~axil.awready;
                wvalid_s  = wvalid_r & ~axil.wready;
                awaddr_s  = awvalid_s ? awaddr_r : '0;
                wdata_s   = wvalid_s ? wdata_r : '0;
                if (!awvalid_s && !wvalid_s) begin
                    state_s = S_RSP;
                end else begin
                    state_s = S_WR;
                end
            end
            S_RD: begin
                // rvalid may arrive before or with arready; each channel retires on its own.
                arvalid_s = arvalid_r & ~axil.arready;
                araddr_s  = arvalid_s ? araddr_r : '0;
                rready_s  = rready_r & ~axil.rvalid;
                if (rready_r && axil.rvalid) begin
                    rdata_s = axil.rdata;
                end else begin
                    rdata_s = rdata_r;
                end
                if (!arvalid_s && !rready_s) begin
`ifdef FIR_CFG_POLL_EN
                    state_s = poll_r ? S_CHK : S_RSP;
`else
                    state_s = S_RSP;
`endif
                end else begin
                    state_s = S_RD;
                end
            end
`ifdef FIR_CFG_POLL_EN
            S_CHK: begin
                cnt_s = (cnt_r == CNT_W'(pPOLL_LIMIT)) ? cnt_r : cnt_r + CNT_W'(1);
                if ((rdata_r & mask_r) != '0) begin
                    state_s   = S_RSP;
                    timeout_s = 1'b0;
                end else if (cnt_s == CNT_W'(pPOLL_LIMIT)) begin
                    state_s   = S_RSP;
                    timeout_s = 1'b1;
                end else begin
                    state_s   = S_RD;
                    arvalid_s = 1'b1;
                    rready_s  = 1'b1;
                    araddr_s  = addr_r;
                end
            end
`endif
            S_RSP: begin
                if (rsp_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_RSP;
                end
            end
            default: begin
                state_s   = S_IDLE;
                awvalid_s = 1'b0;
                wvalid_s  = 1'b0;
                arvalid_s = 1'b0;
                rready_s  = 1'b0;
                awaddr_s  = '0;
                wdata_s   = '0;
                araddr_s  = '0;
            end
        endcase
        cmd_ready_s = (state_s == S_IDLE);
        rsp_valid_s = (state_s == S_RSP);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_r     <= S_IDLE;
            awaddr_r    <= '0;
            araddr_r    <= '0;
            wdata_r     <= '0;
            rdata_r     <= '0;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
`ifdef FIR_CFG_POLL_EN
            poll_r      <= 1'b0;
            timeout_r   <= 1'b0;
            addr_r      <= '0;
            mask_r      <= '0;
            cnt_r       <= '0;
`endif
        end else begin
            state_r     <= state_s;
            awaddr_r    <= awaddr_s;
            araddr_r    <= araddr_s;
            wdata_r     <= wdata_s;
            rdata_r     <= rdata_s;
            awvalid_r   <= awvalid_s;
            wvalid_r    <= wvalid_s;
            arvalid_r   <= arvalid_s;
            rready_r    <= rready_s;
            cmd_ready_r <= cmd_ready_s;
            rsp_valid_r <= rsp_valid_s;
`ifdef FIR_CFG_POLL_EN
            poll_r      <= poll_s;
            timeout_r   <= timeout_s;
            addr_r      <= addr_s;
            mask_r      <= mask_s;
            cnt_r       <= cnt_s;
`endif
        end
    end

    assign cmd_ready    = cmd_ready_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_rdata    = rdata_r;
    assign axil.awvalid = awvalid_r;
    assign axil.awaddr  = awaddr_r;
    assign axil.wvalid  = wvalid_r;
    assign axil.wdata   = wdata_r;
    assign axil.arvalid = arvalid_r;
    assign axil.araddr  = araddr_r;
    assign axil.rready  = rready_r;
`ifdef FIR_CFG_POLL_EN
    assign rsp_timeout  = timeout_r;
`else
    assign rsp_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_fir_cfg_master.sv
// Self-checking bench for fir_cfg_master: directed plan items plus random traffic,
// compared every cycle against a handshake-level model of the command semantics.
`timescale 1ns/1ps
module tb_fir_cfg_master;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          axis_clk = 1'b0;
    logic          axis_rst;
    logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_timeout;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata, rsp_rdata;

    fir_cfg_master_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) axil ();

    fir_cfg_master #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pPOLL_LIMIT(LIM)) dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_timeout(rsp_timeout), .axil(axil)
    );

    always #5 axis_clk = ~axis_clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave knobs and bookkeeping
    bit            rnd = 1'b0;
    bit            started = 1'b0;
    int            aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0, rsp_dly = 0;
    int            aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0, rsp_wait = 0;
    int            n_ar = 0, n_r = 0, aw_high = 0, w_high = 0;
    logic [DW-1:0] rd_q[$];

    // Model state: what the outputs must be, derived from handshake events only
    bit            busy, aw_p, w_p, ar_p, r_p, chk_p, rsp_p, to_m, poll_m, wr_m;
    logic [AW-1:0] addr_m;
    logic [DW-1:0] wd_m, data_m, exp_rd;
    int            att;

    initial begin
        forever begin
            @(posedge axis_clk);
            if (axis_rst) begin
                busy = 0; aw_p = 0; w_p = 0; ar_p = 0; r_p = 0; chk_p = 0; rsp_p = 0;
                to_m = 0; poll_m = 0; wr_m = 0; att = 0; exp_rd = '0;
            end else if (!busy) begin
                if (cmd_valid) begin
                    busy = 1; wr_m = (cmd_op == 2'b00); addr_m = cmd_addr; wd_m = cmd_wdata; att = 0;
`ifdef FIR_CFG_POLL_EN
                    poll_m = (cmd_op == 2'b10);
`else
                    poll_m = 0;
`endif
                    aw_p = wr_m; w_p = wr_m; ar_p = !wr_m; r_p = !wr_m;
                end
            end else if (rsp_p) begin
                if (rsp_ready) begin busy = 0; rsp_p = 0; end
            end else if (chk_p) begin
                chk_p = 0; att++;
                if ((data_m & wd_m) != '0) begin rsp_p = 1; to_m = 0; exp_rd = data_m; end
                else if (att == LIM) begin rsp_p = 1; to_m = 1; exp_rd = data_m; end
                else begin ar_p = 1; r_p = 1; end
            end else begin
                if (aw_p && axil.awready) aw_p = 0;
                if (w_p && axil.wready) w_p = 0;
                if (ar_p && axil.arready) ar_p = 0;
                if (r_p && axil.rvalid) begin r_p = 0; data_m = axil.rdata; end
                if (!aw_p && !w_p && !ar_p && !r_p) begin
                    if (poll_m) chk_p = 1;
                    else begin rsp_p = 1; to_m = 0; exp_rd = wr_m ? '0 : data_m; end
                end
            end
        end
    end

    // Slave wait counters and handshake counters
    initial begin
        forever begin
            @(posedge axis_clk);
            aw_wait  = (axil.awvalid && !axil.awready) ? aw_wait + 1 : 0;
            w_wait   = (axil.wvalid && !axil.wready) ? w_wait + 1 : 0;
            ar_wait  = (axil.arvalid && !axil.arready) ? ar_wait + 1 : 0;
            r_wait   = (axil.rready && !axil.rvalid) ? r_wait + 1 : 0;
            rsp_wait = (rsp_valid && !rsp_ready) ? rsp_wait + 1 : 0;
            if (axil.arvalid && axil.arready) n_ar++;
            if (axil.awvalid) aw_high++;
            if (axil.wvalid) w_high++;
            if (axil.rready && axil.rvalid) begin
                n_r++;
                if (rd_q.size() > 0) void'(rd_q.pop_front());
            end
        end
    end

    // Slave drive on the falling edge
    initial begin
        forever begin
            @(negedge axis_clk);
            if (rnd) begin
                axil.awready = 1'($urandom_range(0, 1));
                axil.wready  = 1'($urandom_range(0, 1));
                axil.arready = 1'($urandom_range(0, 1));
                axil.rvalid  = ($urandom_range(0, 2) == 0);
                rsp_ready    = ($urandom_range(0, 2) != 0);
            end else begin
                axil.awready = (aw_wait >= aw_dly);
                axil.wready  = (w_wait >= w_dly);
                axil.arready = (ar_wait >= ar_dly);
                axil.rvalid  = (r_wait >= r_dly);
                rsp_ready    = (rsp_wait >= rsp_dly);
            end
            if (rd_q.size() > 0) axil.rdata = rd_q[0];
            else if (rnd && $urandom_range(0, 3) == 0) axil.rdata = $urandom;
            else axil.rdata = '0;
        end
    end

    // Compare process: every cycle, DUT outputs against the model
    initial begin
        forever begin
            @(negedge axis_clk);
            if (started) begin
                check("cmd_ready", cmd_ready, !busy);
                check("awvalid", axil.awvalid, aw_p);
                check("awaddr", axil.awaddr, aw_p ? addr_m : '0);
                check("wvalid", axil.wvalid, w_p);
                check("wdata", axil.wdata, w_p ? wd_m : '0);
                check("arvalid", axil.arvalid, ar_p);
                check("araddr", axil.araddr, ar_p ? addr_m : '0);
                check("rready", axil.rready, r_p);
                check("rsp_valid", rsp_valid, rsp_p);
                if (rsp_p) begin
                    check("rsp_rdata", rsp_rdata, exp_rd);
                    check("rsp_timeout", rsp_timeout, to_m);
                end else if (busy && wr_m) begin
                    check("rsp_rdata_wr", rsp_rdata, '0);
                end
            end
        end
    end

    task automatic tick;
        @(negedge axis_clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        check("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [DW-1:0] rd, output logic to);
        int n = 0;
        while (!(rsp_valid && rsp_ready) && n < 3000) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                cmd_valid = 1'b1; cmd_op = 2'($urandom); cmd_addr = AW'($urandom); cmd_wdata = $urandom;
            end else begin
                cmd_valid = 1'b0;
            end
            tick(); n++;
        end
        cmd_valid = 1'b0;
        check("rsp_handshake", rsp_valid && rsp_ready, 1'b1);
        rd = rsp_rdata;
        to = rsp_timeout;
        tick();
    endtask

    task automatic clr_counts;
        n_ar = 0; n_r = 0; aw_high = 0; w_high = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        logic          to;
        int            n;
        axis_rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0;
        axil.awready = 1'b0; axil.wready = 1'b0; axil.arready = 1'b0;
        axil.rvalid = 1'b0; axil.rdata = '0;
        tick();
        started = 1'b1;
        tick(); tick();
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_awvalid", axil.awvalid, 1'b0);
        check("rst_arvalid", axil.arvalid, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, '0);
        check("rst_rsp_timeout", rsp_timeout, 1'b0);
        axis_rst = 1'b0;
        tick();

        // Write with awready delayed 3 cycles
        aw_dly = 3; clr_counts();
        issue(2'b00, 12'h010, 32'd600);
        wait_rsp(rd, to);
        check("wr_aw_high", 64'(aw_high), 64'd4);
        check("wr_w_high", 64'(w_high), 64'd1);
        check("wr_rdata", rd, 32'h0);
        aw_dly = 0;

        // Read, rvalid together with arready
        rd_q.push_back(32'h4); clr_counts();
        issue(2'b01, 12'h000, 32'h0);
        wait_rsp(rd, to);
        check("rd_n_ar", 64'(n_ar), 64'd1);
        check("rd_n_r", 64'(n_r), 64'd1);
        check("rd_rdata", rd, 32'h4);
        check("rd_timeout", to, 1'b0);

        // Read with rvalid one cycle after arready
        r_dly = 1; rd_q.push_back(32'hA5); clr_counts();
        issue(2'b11, 12'h004, 32'h0);
        wait_rsp(rd, to);
        check("rd11_rdata", rd, 32'hA5);
        r_dly = 0;

        // Poll until bit 1 set
        rd_q = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h6}; clr_counts();
        issue(2'b10, 12'h000, 32'h2);
        wait_rsp(rd, to);
`ifdef FIR_CFG_POLL_EN
        check("poll_n_ar", 64'(n_ar), 64'd5);
        check("poll_rdata", rd, 32'h6);
`else
        check("poll_n_ar", 64'(n_ar), 64'd1);
        check("poll_rdata", rd, 32'h0);
`endif
        check("poll_timeout", to, 1'b0);
        rd_q.delete();

        // Poll that never matches
        clr_counts();
        issue(2'b10, 12'h000, 32'hFFFF_FFFF);
        wait_rsp(rd, to);
`ifdef FIR_CFG_POLL_EN
        check("pto_n_ar", 64'(n_ar), 64'd4);
        check("pto_timeout", to, 1'b1);
`else
        check("pto_n_ar", 64'(n_ar), 64'd1);
        check("pto_timeout", to, 1'b0);
`endif
        check("pto_rdata", rd, 32'h0);

        // Reset while awvalid waits on awready
        aw_dly = 20;
        issue(2'b00, 12'h030, 32'h55);
        tick();
        axis_rst = 1'b1;
        tick();
        check("rstmid_awvalid", axil.awvalid, 1'b0);
        check("rstmid_wvalid", axil.wvalid, 1'b0);
        check("rstmid_cmd_ready", cmd_ready, 1'b1);
        check("rstmid_rsp_valid", rsp_valid, 1'b0);
        axis_rst = 1'b0; aw_dly = 0;
        tick();

        // Response held by rsp_ready low for 10 cycles
        rsp_dly = 10; rd_q.push_back(32'h1234);
        issue(2'b01, 12'h020, 32'h0);
        n = 0;
        while (!rsp_valid && n < 100) begin tick(); n++; end
        n = 0;
        while (rsp_valid && !rsp_ready && n < 50) begin
            check("hold_rdata", rsp_rdata, 32'h1234);
            check("hold_cmd_ready", cmd_ready, 1'b0);
            n++;
            tick();
        end
        check("hold_cycles", 64'(n), 64'd10);
        check("hold_release", rsp_valid && rsp_ready, 1'b1);
        tick();
        check("hold_idle", cmd_ready, 1'b1);
        rsp_dly = 0;

        // Random traffic
        rnd = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [1:0]    op;
            logic [DW-1:0] d;
            op = 2'($urandom);
            d  = (op == 2'b10) ? ($urandom & $urandom & $urandom) : $urandom;
            issue(op, AW'($urandom), d);
            wait_rsp(rd, to);
            repeat ($urandom_range(0, 2)) tick();
        end
        rnd = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
